ise_sched: RTL and testbench

- Sequencing controller for the image sorting engine.
- Ingest side: paces the host pixel stream with busy, frames each image for the colour accumulator datapath (acc_en / acc_last), and waits for that image's classification result.
- Result side: insertion-sorts the per-image results into a table and, after the last image, streams the sorted list on out_valid / color_index / image_out_index.

---
 rtl/ise_sched.sv | 118 +++++++++++
 tb/tb_ise_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ise_sched.sv
// ise_sched: paces the pixel stream, frames images and insertion-sorts the per-image results for output
module ise_sched #(
  parameter int IMAGE_NUM  = 32,
  parameter int IMAGE_SIZE = 128,
  parameter int SCORE_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         image_in_index,
  output logic               busy,
  output logic               acc_en,
  output logic               acc_last,
  input  logic               res_valid,
  input  logic [1:0]         res_color,
  input  logic [SCORE_W-1:0] res_score,
  output logic               out_valid,
  output logic [1:0]         color_index,
  output logic [4:0]         image_out_index,
  output logic               proto_err
);
  localparam int PW = 2 * $clog2(IMAGE_SIZE);
  localparam int IW = $clog2(IMAGE_NUM) + 1;
  localparam logic [PW-1:0] PIX_LAST = PW'(IMAGE_SIZE * IMAGE_SIZE - 1);
  typedef enum logic [1:0] {IDLE, ACCEPT, WAIT_RES, OUTPUT} state_t;
  typedef struct packed {
    logic [1:0]         color;
    logic [SCORE_W-1:0] score;
    logic [4:0]         idx;
  } ent_t;
  state_t         state;
  logic [PW-1:0]  pix_cnt;
  logic [IW-1:0]  img_cnt;
  logic [IW-1:0]  rd_ptr;
  logic [4:0]     cur_idx;
  ent_t           tbl [IMAGE_NUM];
  ent_t           ins [IMAGE_NUM];
  ent_t           new_e;
  logic [IMAGE_NUM-1:0] le;
  assign new_e  = '{color: res_color, score: res_score, idx: cur_idx};
  assign acc_en = ~busy;
  // Each slot keeps its entry if it sorts at or before the new one, takes the new
  // entry at the first slot past that prefix, and otherwise shifts down by one.
  for (genvar i = 0; i < IMAGE_NUM; i++) begin : g_ins
    assign le[i] = (IW'(i) < img_cnt) && ({tbl[i].color, tbl[i].score} <= {res_color, res_score});
    if (i == 0) begin : g_head
      assign ins[i] = le[i] ? tbl[i] : new_e;
    end else begin : g_body
      assign ins[i] = le[i] ? tbl[i] : le[i-1] ? new_e : tbl[i-1];
    end
  end
  // Sorted result table; entries at or beyond img_cnt are don't-care.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tbl <= '{default: '0};
    else if (state == WAIT_RES && res_valid) tbl <= ins;
  end
  // Sequencing FSM with registered handshake, framing, output and error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      busy            <= 1'b1;
      acc_last        <= 1'b0;
      out_valid       <= 1'b0;
      color_index     <= '0;
      image_out_index <= '0;
      proto_err       <= 1'b0;
      pix_cnt         <= '0;
      img_cnt         <= '0;
      rd_ptr          <= '0;
      cur_idx         <= '0;
    end else begin
      if (res_valid && (state != WAIT_RES || res_color == 2'd3)) proto_err <= 1'b1;
      case (state)
        IDLE: begin
          state <= ACCEPT;
          busy  <= 1'b0;
        end
        ACCEPT: begin
          if (pix_cnt == '0) cur_idx <= image_in_index;
          else if (image_in_index != cur_idx) proto_err <= 1'b1;
          pix_cnt  <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + 1'b1;
          acc_last <= pix_cnt == PIX_LAST - 1'b1;
          if (pix_cnt == PIX_LAST) begin
            state <= WAIT_RES;
            busy  <= 1'b1;
          end
        end
        WAIT_RES: begin
          if (res_valid) begin
            img_cnt <= img_cnt + 1'b1;
            if (img_cnt == IW'(IMAGE_NUM - 1)) begin
              state           <= OUTPUT;
              out_valid       <= 1'b1;
              color_index     <= ins[0].color;
              image_out_index <= ins[0].idx;
              rd_ptr          <= IW'(1);
            end else begin
              state <= ACCEPT;
              busy  <= 1'b0;
            end
          end
        end
        OUTPUT: begin
          if (rd_ptr == IW'(IMAGE_NUM)) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            img_cnt   <= '0;
            rd_ptr    <= '0;
          end else begin
            color_index     <= tbl[rd_ptr[IW-2:0]].color;
            image_out_index <= tbl[rd_ptr[IW-2:0]].idx;
            rd_ptr          <= rd_ptr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ise_sched.sv
// tb_ise_sched: randomized batches checked every cycle against a transaction-level model of the scheduler
module tb_ise_sched;
  localparam int N    = 4;
  localparam int S    = 4;
  localparam int NPIX = S * S;
  localparam int SW   = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    image_in_index = '0;
  logic          res_valid = 1'b0;
  logic [1:0]    res_color = '0;
  logic [SW-1:0] res_score = '0;
  logic          busy, acc_en, acc_last, out_valid, proto_err;
  logic [1:0]    color_index;
  logic [4:0]    image_out_index;

  int n_chk = 0;
  int n_fail = 0;
  int cap_c[$];
  int cap_i[$];
  int ec[4] = '{0, 0, 1, 1};
  int ei[4] = '{1, 3, 2, 0};
  int c2, c5, col2;

  ise_sched #(.IMAGE_NUM(N), .IMAGE_SIZE(S), .SCORE_W(SW)) dut (
    .clk(clk), .reset(reset), .image_in_index(image_in_index),
    .busy(busy), .acc_en(acc_en), .acc_last(acc_last),
    .res_valid(res_valid), .res_color(res_color), .res_score(res_score),
    .out_valid(out_valid), .color_index(color_index),
    .image_out_index(image_out_index), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: results kept in arrival order, ordered only when the batch is complete.
  typedef struct {int c; int s; int i;} res_t;
  res_t arr[$];
  res_t srt[$];
  int ph = 0, pix = 0, cur = 0, rd = 0, oc = 0, oi = 0;
  bit err = 0, ov = 0;

  // Stable ordering by repeated selection of the smallest (colour, score), earliest arrival on ties.
  function automatic void order();
    bit used[N];
    srt.delete();
    for (int k = 0; k < N; k++) used[k] = 0;
    for (int k = 0; k < N; k++) begin
      int b = -1;
      for (int j = 0; j < N; j++)
        if (!used[j] && (b < 0 || arr[j].c < arr[b].c || (arr[j].c == arr[b].c && arr[j].s < arr[b].s))) b = j;
      used[b] = 1;
      srt.push_back(arr[b]);
    end
  endfunction

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      ph = 0; pix = 0; cur = 0; rd = 0; oc = 0; oi = 0; err = 0; ov = 0;
      arr.delete();
    end else if (ph == 0) begin
      ph = 1;
    end else if (ph == 1) begin
      if (res_valid) err = 1;
      if (pix == 0) cur = int'(image_in_index);
      else if (int'(image_in_index) != cur) err = 1;
      pix++;
      if (pix == NPIX) begin pix = 0; ph = 2; end
    end else if (ph == 2) begin
      if (res_valid) begin
        if (res_color == 2'd3) err = 1;
        arr.push_back('{int'(res_color), int'(res_score), cur});
        if (arr.size() == N) begin
          order();
          ph = 3; rd = 0; ov = 1; oc = srt[0].c; oi = srt[0].i;
        end else ph = 1;
      end
    end else begin
      if (res_valid) err = 1;
      rd++;
      if (rd == N) begin ov = 0; ph = 0; arr.delete(); end
      else begin oc = srt[rd].c; oi = srt[rd].i; end
    end
  end

  // Every-cycle comparison against the model, plus capture of the output stream.
  initial forever begin
    @(negedge clk);
    chk("busy", busy, ph != 1);
    chk("acc_en", acc_en, ph == 1);
    chk("acc_last", acc_last, ph == 1 && pix == NPIX - 1);
    chk("out_valid", out_valid, ov);
    chk("color_index", color_index, oc);
    chk("image_out_index", image_out_index, oi);
    chk("proto_err", proto_err, err);
    if (out_valid) begin
      cap_c.push_back(int'(color_index));
      cap_i.push_back(int'(image_out_index));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Called at a falling edge; drives one image, optionally switching index at pixel chg and pulsing res_valid at pixel pulse.
  task automatic send_image(input int idx, input int alt, input int chg, input int pulse);
    int n = 0, t = 0, last_at = -1, lasts = 0;
    while (n < NPIX && t < 400) begin
      res_valid = 1'b0;
      if (!busy) begin
        if (acc_last) begin lasts++; last_at = n; end
        image_in_index = 5'(n >= chg ? alt : idx);
        if (n == pulse) res_valid = 1'b1;
        n++;
      end
      @(negedge clk);
      t++;
    end
    res_valid = 1'b0;
    chk("img_done", t < 400, 1);
    chk("acc_last_pos", last_at, NPIX - 1);
    chk("acc_last_cnt", lasts, 1);
  endtask

  task automatic send_res(input int c, input int s, input int dly);
    repeat (dly) begin
      chk("busy_wait", busy, 1);
      @(negedge clk);
    end
    res_valid = 1'b1;
    res_color = 2'(c);
    res_score = SW'(s);
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic wait_out();
    int t = 0;
    while (!out_valid && t < 20) begin @(negedge clk); t++; end
    while (out_valid && t < 100) begin @(negedge clk); t++; end
    chk("out_done", t < 100, 1);
  endtask

  task automatic rand_batch();
    cap_c.delete();
    cap_i.delete();
    for (int k = 0; k < N; k++) begin
      int idx = int'($urandom_range(0, 31));
      int chg = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, NPIX - 1)) : 99;
      send_image(idx, idx ^ 1, chg, 99);
      send_res(($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
    end
    wait_out();
    chk("rand_out_len", cap_c.size(), N);
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_busy", busy, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_proto_err", proto_err, 0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("busy_after_release", busy, 0);

    // sort with a stable tie, first result delayed 50 cycles
    cap_c.delete();
    cap_i.delete();
    send_image(0, 0, 99, 99); send_res(1, 40, 50);
    send_image(1, 1, 99, 99); send_res(0, 90, 0);
    send_image(2, 2, 99, 99); send_res(1, 10, 2);
    send_image(3, 3, 99, 99); send_res(0, 90, 1);
    wait_out();
    chk("sort_len", cap_c.size(), 4);
    for (int k = 0; k < 4 && k < cap_c.size(); k++) begin
      chk("sort_color", cap_c[k], ec[k]);
      chk("sort_index", cap_i[k], ei[k]);
    end
    chk("proto_err_clean", proto_err, 0);
    @(negedge clk);
    chk("accept_after_out", busy, 0);

    // index change 2->5 mid-image and res_valid during ACCEPT
    cap_c.delete();
    cap_i.delete();
    send_image(2, 5, 8, 4);
    chk("proto_err_set", proto_err, 1);
    send_res(2, 7, 0);
    for (int k = 1; k < N; k++) begin
      send_image(10 + k, 10 + k, 99, 99);
      send_res(int'($urandom_range(0, 2)), int'($urandom_range(0, 9)), int'($urandom_range(0, 3)));
    end
    wait_out();
    c2 = 0; c5 = 0; col2 = -1;
    foreach (cap_i[k]) begin
      if (cap_i[k] == 2) begin c2++; col2 = cap_c[k]; end
      if (cap_i[k] == 5) c5++;
    end
    chk("proto_len", cap_c.size(), 4);
    chk("proto_idx2_cnt", c2, 1);
    chk("proto_idx5_cnt", c5, 0);
    chk("proto_idx2_color", col2, 2);
    chk("proto_err_sticky", proto_err, 1);

    // reset after two results
    send_image(7, 7, 99, 99); send_res(2, 3, 0);
    send_image(8, 8, 99, 99); send_res(1, 3, 0);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_acc_last", acc_last, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_color", color_index, 0);
    chk("mid_rst_index", image_out_index, 0);
    chk("mid_rst_proto_err", proto_err, 0);
    @(negedge clk);
    reset = 1'b1;

    // fresh batch, with a stray result strobe while outputting
    cap_c.delete();
    cap_i.delete();
    for (int k = 0; k < N; k++) begin
      send_image(20 + k, 20 + k, 99, 99);
      send_res(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    chk("out_during_pulse", out_valid, 1);
    res_valid = 1'b1;
    res_color = 2'd1;
    @(negedge clk);
    res_valid = 1'b0;
    wait_out();
    chk("fresh_len", cap_c.size(), 4);
    foreach (cap_i[k]) chk("fresh_own_entry", cap_i[k] >= 20 && cap_i[k] <= 23, 1);
    chk("out_pulse_err", proto_err, 1);

    repeat (6) rand_batch();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
